// File: rtl/mem_mp_pkg.sv
// Shared types and helpers for the multi-port memory controller.
// MEM_MP_PARITY_EN widens each stored word by one even-parity bit.
package mem_mp_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

`ifdef MEM_MP_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam int MAX_CH = 8;

    // First requesting channel after ptr, wrapping modulo nch; returns ptr when none request.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                           input logic [2:0]        ptr,
                                           input int                nch);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = (int'(ptr) + k) % nch;
            if ((k <= nch) && !found && valid[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_mp_rr_arb.sv
// Round-robin arbiter: one-hot grant among valid requesters, pointer remembers last winner.
module mem_mp_rr_arb
    import mem_mp_pkg::*;
#(
    parameter  int NCH = 2,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic [NCH-1:0] req_valid_i,
    output logic [NCH-1:0] grant_o,
    output logic [IW-1:0]  idx_o
);

    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [MAX_CH-1:0] valid_ext_s;
    logic [2:0]        pick_s;
    logic              any_s;

    // Any grant is a transfer, since a grant is only ever given to a valid requester.
    always_comb begin
        valid_ext_s = en_i ? MAX_CH'(req_valid_i) : '0;
        any_s       = |valid_ext_s;
        pick_s      = rr_pick(valid_ext_s, 3'(ptr_q), NCH);
        idx_o       = IW'(pick_s);
        if (any_s) begin
            grant_o = NCH'(1'b1) << pick_s;
            ptr_d   = IW'(pick_s);
        end else begin
            grant_o = '0;
            ptr_d   = ptr_q;
        end
    end

    // Pointer register; resets so that channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(NCH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_mp_ctrl.sv
// NCH-channel controller for a single-port DEPTH x WIDTH array with init-clear and 1-cycle reads.
// Define MEM_MP_PARITY_EN to store an even-parity bit per word and add the err_inj input.
module mem_mp_ctrl
    import mem_mp_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    parameter  int NCH   = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef MEM_MP_PARITY_EN
    input  logic                 err_inj,
`endif
    input  logic [NCH-1:0]       req_valid,
    output logic [NCH-1:0]       req_ready,
    input  logic [NCH-1:0]       req_we,
    input  logic [NCH*AW-1:0]    req_addr,
    input  logic [NCH*WIDTH-1:0] req_wdata,
    output logic [NCH-1:0]       rsp_valid,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_err,
    output logic                 init_done
);

    localparam int          IW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          MW      = WIDTH + PAR_W;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [MW-1:0]    mem_q [DEPTH];
    logic [NCH-1:0]   grant_s;
    logic [IW-1:0]    idx_s;
    logic             xfer_s, sel_we_s, in_range_s, wr_en_s, par_bad_s, rd_err_s;
    logic [AW-1:0]    sel_addr_s;
    logic [WIDTH-1:0] sel_wdata_s, rd_data_s;
    logic [MW-1:0]    rd_word_s, wr_word_s;
    logic [NCH-1:0]   rsp_valid_q;
    logic [WIDTH-1:0] rsp_rdata_q;
    logic             rsp_err_q, init_done_q;

`ifdef MEM_MP_PARITY_EN
    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    mem_mp_rr_arb #(.NCH(NCH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == RUN),
        .req_valid_i (req_valid),
        .grant_o     (grant_s),
        .idx_o       (idx_s)
    );

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

    // Init sweep: one word cleared per cycle, then hand over to normal operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // FSM and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Route the granted channel onto the shared array port and form the response.
    always_comb begin
        xfer_s      = |grant_s;
        sel_we_s    = req_we[idx_s];
        sel_addr_s  = req_addr[int'(idx_s) * AW +: AW];
        sel_wdata_s = req_wdata[int'(idx_s) * WIDTH +: WIDTH];
        in_range_s  = ({1'b0, sel_addr_s} < DEPTH_L);
        wr_en_s     = xfer_s && sel_we_s && in_range_s;
        rd_word_s   = in_range_s ? mem_q[sel_addr_s] : '0;
`ifdef MEM_MP_PARITY_EN
        wr_word_s   = {even_par(sel_wdata_s) ^ err_inj, sel_wdata_s};
        par_bad_s   = (even_par(rd_word_s[WIDTH-1:0]) != rd_word_s[WIDTH]);
`else
        wr_word_s   = sel_wdata_s;
        par_bad_s   = 1'b0;
`endif
        if (xfer_s && !sel_we_s) begin
            rd_data_s = rd_word_s[WIDTH-1:0];
            rd_err_s  = !in_range_s || par_bad_s;
        end else begin
            rd_data_s = '0;
            rd_err_s  = xfer_s && !in_range_s;
        end
    end

    // Storage array: no reset, contents are defined by the init sweep.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en_s) begin
            mem_q[sel_addr_s] <= wr_word_s;
        end
    end

    // Registered response and init status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            rsp_valid_q <= grant_s;
            rsp_rdata_q <= rd_data_s;
            rsp_err_q   <= rd_err_s;
            init_done_q <= (state_q == RUN);
        end
    end

endmodule

// File: tb/tb_mem_mp_ctrl.sv
// Scoreboard bench for mem_mp_ctrl (DEPTH=20 so out-of-range addresses exist, NCH=3).
// Parity checks are compiled in when MEM_MP_PARITY_EN is defined.
module tb_mem_mp_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 20;
    localparam int NCH   = 3;
    localparam int AW    = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NCH-1:0]       req_valid = '0;
    logic [NCH-1:0]       req_we = '0;
    logic [NCH*AW-1:0]    req_addr = '0;
    logic [NCH*WIDTH-1:0] req_wdata = '0;
    logic [NCH-1:0]       req_ready;
    logic [NCH-1:0]       rsp_valid;
    logic [WIDTH-1:0]     rsp_rdata;
    logic                 rsp_err;
    logic                 init_done;
    logic                 err_inj = 1'b0;

    always #5 clk = ~clk;

    mem_mp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MEM_MP_PARITY_EN
        .err_inj   (err_inj),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    typedef struct {
        int ch;
        int data;
        bit err;
        int due;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    int             model_mem [DEPTH];
    bit             model_bad [DEPTH];
    int             last_ch, init_left, since_rst, last_xfer;
    logic [NCH-1:0] ready_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1 << mon_e.ch));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.data));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                chk("rsp_latency", 64'(cyc), 64'(mon_e.due));
            end
        end else begin
            chk("idle_rsp", 64'({rsp_err, rsp_rdata}), 64'(0));
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_rsp", 64'(rsp_valid), 64'(1 << sb[0].ch));
                void'(sb.pop_front());
            end
        end
    end

    task automatic set_req(input int ch, input bit we, input int addr, input int data);
        req_valid = req_valid | (NCH'(1) << ch);
        if (we) req_we = req_we | (NCH'(1) << ch);
        else    req_we = req_we & ~(NCH'(1) << ch);
        req_addr[ch*AW +: AW]       = AW'(addr);
        req_wdata[ch*WIDTH +: WIDTH] = WIDTH'(data);
    endtask

    task automatic expect_xfer(input int g);
        exp_t e;
        int   a;
        a      = int'(req_addr[g*AW +: AW]);
        e.ch   = g;
        e.due  = cyc + 1;
        if (a >= DEPTH) begin
            e.data = 0;
            e.err  = 1'b1;
        end else if (((req_we >> g) & NCH'(1)) != '0) begin
            model_mem[a] = int'(req_wdata[g*WIDTH +: WIDTH]);
            model_bad[a] = err_inj;
            e.data = 0;
            e.err  = 1'b0;
        end else begin
            e.data = model_mem[a];
            e.err  = model_bad[a];
        end
        sb.push_back(e);
    endtask

    // One clock: predict the grant from the round-robin rule, check it, record the transfer.
    task automatic tick();
        int g;
        int c;
        @(negedge clk);
        g = -1;
        if (init_left == 0) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (last_ch + k) % NCH;
                if (g < 0 && ((req_valid >> c) & NCH'(1)) != '0) g = c;
            end
        end
        ready_seen = req_ready;
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'(0));
        chk("init_done", 64'(init_done), 64'(since_rst >= DEPTH + 1));
        last_xfer = g;
        if (g >= 0) begin
            expect_xfer(g);
            last_ch = g;
        end
        @(posedge clk);
        #1;
        since_rst++;
        if (init_left > 0) init_left--;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b0;
        since_rst = 0;
        init_left = DEPTH;
        last_ch   = NCH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 0;
            model_bad[i] = 1'b0;
        end
    endtask

    task automatic issue(input int ch, input bit we, input int addr, input int data);
        bit done;
        done      = 1'b0;
        req_valid = '0;
        set_req(ch, we, addr, data);
        for (int t = 0; t < 8 && !done; t++) begin
            tick();
            if (last_xfer == ch) done = 1'b1;
        end
        if (!done) chk("grant_timeout", 64'(req_ready), 64'(1 << ch));
        req_valid = '0;
    endtask

    task automatic rand_step();
        int a;
        for (int c = 0; c < NCH; c++) begin
            if (c == last_xfer || ((req_valid >> c) & NCH'(1)) == '0) begin
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
                if ($urandom_range(0, 99) < 55)
                    set_req(c, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 255)));
                else
                    req_valid = req_valid & ~(NCH'(1) << c);
            end else if ($urandom_range(0, 99) < 8) begin
                req_valid = req_valid & ~(NCH'(1) << c);
            end
        end
`ifdef MEM_MP_PARITY_EN
        err_inj = ($urandom_range(0, 3) == 0);
`endif
    endtask

    initial begin
        last_xfer = -1;
        #1;
        do_reset();
        repeat (DEPTH + 3) tick();

        // Fairness straight after init: pointer starts at NCH-1, so ch0 wins first.
        req_valid = '0;
        set_req(0, 1'b0, 1, 0);
        set_req(1, 1'b0, 2, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_order", 64'(ready_seen), 64'(1 << (i % 2)));
        end
        req_valid = '0;

        issue(0, 1'b0, 0, 0);
        issue(1, 1'b0, 15, 0);
        issue(2, 1'b0, DEPTH - 1, 0);

        issue(0, 1'b1, 5, 'hA5);
        issue(0, 1'b0, 5, 0);

        issue(1, 1'b1, 25, 'h3C);
        issue(1, 1'b0, 25, 0);
        issue(2, 1'b0, 31, 0);
        for (int a = 0; a < DEPTH; a++) issue(a % NCH, 1'b0, a, 0);

        // Single requester gets consecutive grants.
        for (int i = 0; i < 6; i++) begin
            set_req(2, 1'(i % 2 == 0), 7, i * 17 + 3);
            tick();
            chk("b2b_grant", 64'(ready_seen), 64'(4));
        end
        req_valid = '0;

        // Reset right after a read transfer: its response must never appear.
        issue(0, 1'b0, 5, 0);
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            rand_step();
            tick();
        end
        issue(0, 1'b0, 5, 0);

`ifdef MEM_MP_PARITY_EN
        err_inj = 1'b1;
        issue(0, 1'b1, 3, 'h0F);
        err_inj = 1'b0;
        issue(0, 1'b0, 3, 0);
        issue(0, 1'b1, 3, 'h0F);
        issue(0, 1'b0, 3, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            rand_step();
            tick();
        end
        req_valid = '0;
        err_inj   = 1'b0;
        repeat (3) tick();
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
